// File: rtl/adder_serial_controller.sv
// ---------------------------------------------------------------------------
// adder_serial_controller
//
// Bit-serial WIDTH-bit adder sequencer. One full-adder slice is built from two
// adder_half_1bit instances and an OR gate. It is reused once per bit, LSB
// first, over WIDTH clock cycles, with the carry held in a flop between bits.
// A host sequencer drives it through a start / busy / done handshake.
//
// Parameters
//   WIDTH      operand and sum width in bits (>= 2)
//
// Ports
//   Clk        input   1      rising-edge clock
//   Reset_n    input   1      asynchronous active-low reset
//   start      input   1      request, accepted only while busy == 0
//   operand_a  input   WIDTH  addend A, sampled on the accept edge
//   operand_b  input   WIDTH  addend B, sampled on the accept edge
//   carry_in   input   1      initial carry, sampled on the accept edge
//   busy       output  1      high while a request is in progress (RUN, DONE)
//   done       output  1      one-cycle pulse when sum/carry_out are fresh
//   sum        output  WIDTH  result, held until the next final-bit edge
//   carry_out  output  1      final carry, held with sum
//   overflow   output  1      (only with SERIAL_ADDER_OVERFLOW_EN) signed
//                             two's-complement overflow, held with sum
//
// Build option
//   SERIAL_ADDER_OVERFLOW_EN  when defined, adds the overflow output.
// ---------------------------------------------------------------------------

module adder_half_1bit (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module adder_serial_controller #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 sum bits produced so far; the final bit comes straight
  // from the slice on the last edge, so a full WIDTH-bit register is not needed.
  logic [WIDTH-2:0] sum_sh;
  logic             carry_q;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             last_bit;

  logic             ha0_sum, ha0_carry;
  logic             slice_sum, ha1_carry;
  logic             slice_carry;
  logic [WIDTH-1:0] sum_ext;

  // Shared full-adder slice: A[0] + B[0] + carry
  adder_half_1bit u_ha0 (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  adder_half_1bit u_ha1 (
    .a     (ha0_sum),
    .b     (carry_q),
    .sum   (slice_sum),
    .carry (ha1_carry)
  );

  assign slice_carry = ha0_carry | ha1_carry;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign sum_ext  = {slice_sum, sum_sh};

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == RUN) && (count == LAST_BIT);

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      RUN:     busy = 1'b1;
      DONE:    begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Serial datapath: operand shift registers, carry flop, bit counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      count   <= '0;
    end else if (accept) begin
      a_sh    <= operand_a;
      b_sh    <= operand_b;
      carry_q <= carry_in;
      count   <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= sum_ext[WIDTH-1:1];
      carry_q <= slice_carry;
      count   <= count + CNT_W'(1);
    end
  end

  // Result registers: only the final-bit edge updates them
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (last_bit) begin
      sum       <= sum_ext;
      carry_out <= slice_carry;
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  // On the last bit carry_q is the carry into the MSB, slice_carry the carry out.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      overflow <= 1'b0;
    end else if (last_bit) begin
      overflow <= carry_q ^ slice_carry;
    end
  end
`endif

endmodule
